queue_output_arbiter: RTL and testbench



---
 rtl/queue_output_arbiter.sv | 117 +++++++++++
 tb/tb_queue_output_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/queue_output_arbiter.sv
// Round-robin arbiter that pops entries from several fifo queues and presents
// them one at a time on a single registered valid/ack output port.
module queue_output_arbiter #(
    parameter int NUM_QUEUES                 = 4,
    parameter int NUM_QUEUES_WIDTH_IN_BITS   = 2,
    parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 64
) (
    input  logic                                             clk_in,
    input  logic                                             reset_in,
    input  logic [NUM_QUEUES*SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_packed_in,
    input  logic [NUM_QUEUES-1:0]                            request_valid_packed_in,
    output logic [NUM_QUEUES-1:0]                            issue_ack_packed_out,
    output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]            request_out,
    output logic                                             request_valid_out,
    input  logic                                             issue_ack_in,
    output logic [NUM_QUEUES_WIDTH_IN_BITS-1:0]              granted_queue_out
);

    localparam int QW = NUM_QUEUES_WIDTH_IN_BITS;
    localparam int W  = SINGLE_ENTRY_WIDTH_IN_BITS;

    localparam logic [0:0]    IDLE     = 1'b0;
    localparam logic [0:0]    BUSY     = 1'b1;
    localparam logic [QW-1:0] LAST_IDX = QW'(NUM_QUEUES - 1);

    logic [0:0]            state_q, state_d;
    logic [QW-1:0]         last_grant_q, last_grant_d;
    logic [W-1:0]          request_q, request_d;
    logic                  request_valid_q, request_valid_d;
    logic [QW-1:0]         granted_q, granted_d;
    logic [NUM_QUEUES-1:0] issue_ack_q, issue_ack_d;

    logic [QW-1:0]         cursor;
    logic [QW-1:0]         winner;
    logic                  found;
    logic [W-1:0]          winner_entry;
    logic [NUM_QUEUES-1:0] winner_onehot;

    // Walk the queues starting just after the last grant; the explicit wrap at
    // LAST_IDX keeps non-power-of-two counts from ever reaching unused indices.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cursor = last_grant_q;
        for (int k = 0; k < NUM_QUEUES; k++) begin
            cursor = (cursor == LAST_IDX) ? '0 : cursor + QW'(1);
            if (!found && request_valid_packed_in[cursor]) begin
                found  = 1'b1;
                winner = cursor;
            end
        end
    end

    always_comb begin
        winner_entry  = '0;
        winner_onehot = '0;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            if (winner == QW'(i)) begin
                winner_entry     = request_packed_in[i*W +: W];
                winner_onehot[i] = 1'b1;
            end
        end
    end

    // The pop pulse defaults low so it lasts exactly one cycle per grant; the
    // upstream valid is ignored while busy to hide the fifo's post-pop lag.
    always_comb begin
        state_d         = state_q;
        last_grant_d    = last_grant_q;
        request_d       = request_q;
        request_valid_d = request_valid_q;
        granted_d       = granted_q;
        issue_ack_d     = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    request_d       = winner_entry;
                    granted_d       = winner;
                    request_valid_d = 1'b1;
                    issue_ack_d     = winner_onehot;
                    last_grant_d    = winner;
                    state_d         = BUSY;
                end
            end
            default: begin
                if (issue_ack_in) begin
                    request_valid_d = 1'b0;
                    state_d         = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q         <= IDLE;
            last_grant_q    <= LAST_IDX;
            request_q       <= '0;
            request_valid_q <= 1'b0;
            granted_q       <= '0;
            issue_ack_q     <= '0;
        end else begin
            state_q         <= state_d;
            last_grant_q    <= last_grant_d;
            request_q       <= request_d;
            request_valid_q <= request_valid_d;
            granted_q       <= granted_d;
            issue_ack_q     <= issue_ack_d;
        end
    end

    assign issue_ack_packed_out = issue_ack_q;
    assign request_out          = request_q;
    assign request_valid_out    = request_valid_q;
    assign granted_queue_out    = granted_q;

endmodule

// File: tb/tb_queue_output_arbiter.sv
// Self-checking bench: a 4-queue arbiter driven by vectors and a fifo model,
// plus a 3-queue arbiter drained end-to-end from modelled fifos.
module tb_queue_output_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset      = 1'b1;
    logic         use_model  = 1'b0;
    logic [3:0]   table_mask = '0;
    logic [255:0] table_data = '0;
    logic         iss_a      = 1'b0;
    logic         iss_b      = 1'b0;

    logic [255:0] data_a;
    logic [3:0]   valid_a, ack_a;
    logic [63:0]  out_a;
    logic         vout_a;
    logic [1:0]   gnt_a;

    logic [191:0] data_b;
    logic [2:0]   valid_b, ack_b;
    logic [63:0]  out_b;
    logic         vout_b;
    logic [1:0]   gnt_b;

    // Queues 0..3 feed the 4-queue DUT, 4..6 feed the 3-queue DUT.
    logic [63:0] qmem [0:6][0:15];
    int          qhead [7];
    int          qtail [7];

    int n_cmp  = 0;
    int n_fail = 0;

    logic [63:0] got_data [$];
    logic [1:0]  got_grant [$];
    int          pulses;
    int          bad_pulse;

    typedef struct {
        logic [3:0] mask;
        logic [1:0] grant;
    } vec_t;
    vec_t vecs [12];

    queue_output_arbiter #(
        .NUM_QUEUES(4), .NUM_QUEUES_WIDTH_IN_BITS(2), .SINGLE_ENTRY_WIDTH_IN_BITS(64)
    ) dut_a (
        .clk_in(clk), .reset_in(reset),
        .request_packed_in(data_a), .request_valid_packed_in(valid_a),
        .issue_ack_packed_out(ack_a), .request_out(out_a),
        .request_valid_out(vout_a), .issue_ack_in(iss_a),
        .granted_queue_out(gnt_a)
    );

    queue_output_arbiter #(
        .NUM_QUEUES(3), .NUM_QUEUES_WIDTH_IN_BITS(2), .SINGLE_ENTRY_WIDTH_IN_BITS(64)
    ) dut_b (
        .clk_in(clk), .reset_in(reset),
        .request_packed_in(data_b), .request_valid_packed_in(valid_b),
        .issue_ack_packed_out(ack_b), .request_out(out_b),
        .request_valid_out(vout_b), .issue_ack_in(iss_b),
        .granted_queue_out(gnt_b)
    );

    // Fifo model outputs: valid while non-empty, head entry on the data slot.
    always_comb begin
        valid_a = table_mask;
        data_a  = table_data;
        valid_b = '0;
        data_b  = '0;
        if (use_model) begin
            for (int i = 0; i < 4; i++) begin
                valid_a[i]         = (qtail[i] != qhead[i]);
                data_a[i*64 +: 64] = qmem[i][4'(qhead[i])];
            end
        end
        for (int i = 0; i < 3; i++) begin
            valid_b[i]         = (qtail[i+4] != qhead[i+4]);
            data_b[i*64 +: 64] = qmem[i+4][4'(qhead[i+4])];
        end
    end

    // Fifo model pops on the arbiter's ack pulse, and empties on reset.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (reset) qhead[i] <= 0;
            else if (ack_a[i] && qtail[i] != qhead[i]) qhead[i] <= qhead[i] + 1;
        end
        for (int i = 0; i < 3; i++) begin
            if (reset) qhead[i+4] <= 0;
            else if (ack_b[i] && qtail[i+4] != qhead[i+4]) qhead[i+4] <= qhead[i+4] + 1;
        end
    end

    function automatic logic [63:0] tdata(input int n, input int i);
        return 64'hA5A5_0000_0000_0000 | (64'(n) << 8) | 64'(i);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic setTableData(input int n);
        for (int i = 0; i < 4; i++) table_data[i*64 +: 64] = tdata(n, i);
    endtask

    task automatic resetAll();
        @(negedge clk);
        reset      = 1'b1;
        iss_a      = 1'b0;
        iss_b      = 1'b0;
        table_mask = '0;
        for (int i = 0; i < 7; i++) qtail[i] = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic applyStimulus(input logic [3:0] mask, input int n);
        @(negedge clk);
        iss_a      = 1'b0;
        table_mask = mask;
        setTableData(n);
        @(posedge clk);
        #1;
    endtask

    // Consumer that acks each entry one cycle after it becomes valid.
    task automatic drain(input bit use_b, input int n, input int budget);
        int         cyc;
        bit         ack_drv;
        logic [3:0] vec;
        logic       v;
        cyc       = 0;
        ack_drv   = 1'b0;
        pulses    = 0;
        bad_pulse = 0;
        got_data.delete();
        got_grant.delete();
        while (got_data.size() < n && cyc < budget) begin
            @(posedge clk);
            #1;
            cyc++;
            vec = use_b ? {1'b0, ack_b} : ack_a;
            v   = use_b ? vout_b : vout_a;
            pulses += $countones(vec);
            if (vec != 0 && !$onehot(vec)) bad_pulse++;
            if (v && !ack_drv) begin
                got_data.push_back(use_b ? out_b : out_a);
                got_grant.push_back(use_b ? gnt_b : gnt_a);
                ack_drv = 1'b1;
            end else begin
                ack_drv = 1'b0;
            end
            iss_a = use_b ? 1'b0 : ack_drv;
            iss_b = use_b ? ack_drv : 1'b0;
        end
        @(posedge clk);
        #1;
        iss_a = 1'b0;
        iss_b = 1'b0;
        checkOutput("drain_count", 64'(got_data.size()), 64'(n));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] exp_t2 [8];
        logic [3:0]  ack_exp [8];
        logic        vout_exp [8];
        int          next_k [3];

        vecs[0]  = '{4'b1111, 2'd0};
        vecs[1]  = '{4'b1111, 2'd1};
        vecs[2]  = '{4'b1010, 2'd3};
        vecs[3]  = '{4'b1010, 2'd1};
        vecs[4]  = '{4'b1010, 2'd3};
        vecs[5]  = '{4'b0001, 2'd0};
        vecs[6]  = '{4'b0001, 2'd0};
        vecs[7]  = '{4'b0100, 2'd2};
        vecs[8]  = '{4'b1001, 2'd3};
        vecs[9]  = '{4'b1001, 2'd0};
        vecs[10] = '{4'b0110, 2'd1};
        vecs[11] = '{4'b0110, 2'd2};
        for (int i = 0; i < 7; i++) qtail[i] = 0;

        // Reset values on both instances.
        resetAll();
        checkOutput("rst_out_a",   out_a, 64'd0);
        checkOutput("rst_valid_a", 64'(vout_a), 64'd0);
        checkOutput("rst_gnt_a",   64'(gnt_a), 64'd0);
        checkOutput("rst_ack_a",   64'(ack_a), 64'd0);
        checkOutput("rst_valid_b", 64'(vout_b), 64'd0);
        checkOutput("rst_ack_b",   64'(ack_b), 64'd0);

        // Rotation, wrap and single-queue vectors starting from last_grant=3.
        for (int n = 0; n < 12; n++) begin
            applyStimulus(vecs[n].mask, n);
            checkOutput($sformatf("tbl%0d_grant", n), 64'(gnt_a), 64'(vecs[n].grant));
            checkOutput($sformatf("tbl%0d_data", n), out_a, tdata(n, int'(vecs[n].grant)));
            checkOutput($sformatf("tbl%0d_valid", n), 64'(vout_a), 64'd1);
            checkOutput($sformatf("tbl%0d_pulse", n), 64'(ack_a), 64'(4'b0001 << vecs[n].grant));
            @(negedge clk);
            table_mask = '0;
            iss_a      = 1'b1;
            @(posedge clk);
            #1;
            checkOutput($sformatf("tbl%0d_valid_drop", n), 64'(vout_a), 64'd0);
            checkOutput($sformatf("tbl%0d_pulse_end", n), 64'(ack_a), 64'd0);
        end
        @(negedge clk);
        iss_a = 1'b0;

        // Reset while busy drops the entry and restores queue 0 priority.
        resetAll();
        setTableData(99);
        table_mask = 4'b0100;
        @(posedge clk);
        #1;
        checkOutput("rb_pre_grant", 64'(gnt_a), 64'd2);
        checkOutput("rb_pre_valid", 64'(vout_a), 64'd1);
        @(negedge clk);
        reset      = 1'b1;
        table_mask = 4'b1111;
        @(posedge clk);
        #1;
        checkOutput("rb_out",   out_a, 64'd0);
        checkOutput("rb_valid", 64'(vout_a), 64'd0);
        checkOutput("rb_gnt",   64'(gnt_a), 64'd0);
        checkOutput("rb_ack",   64'(ack_a), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rb_next_grant", 64'(gnt_a), 64'd0);
        checkOutput("rb_next_valid", 64'(vout_a), 64'd1);
        checkOutput("rb_next_data",  out_a, tdata(99, 0));
        checkOutput("rb_next_pulse", 64'(ack_a), 64'd1);

        // Consumer ack held high: one pulse per grant, one grant per two cycles.
        ack_exp  = '{4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1};
        vout_exp = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        @(negedge clk);
        iss_a = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("hold_ack%0d_pulse", c), 64'(ack_a), 64'(ack_exp[c]));
            checkOutput($sformatf("hold_ack%0d_valid", c), 64'(vout_a), 64'(vout_exp[c]));
        end
        @(negedge clk);
        iss_a      = 1'b0;
        table_mask = '0;

        // Queue 0 alone with three entries.
        resetAll();
        use_model  = 1'b1;
        qmem[0][0] = 64'hFFFF_FFFF_FFFF_FFFF;
        qmem[0][1] = 64'hFFFF_FFFF_FFFF_FFFE;
        qmem[0][2] = 64'hFFFF_FFFF_FFFF_FFFD;
        qtail[0]   = 3;
        drain(1'b0, 3, 60);
        for (int j = 0; j < got_data.size(); j++) begin
            checkOutput($sformatf("q0_data%0d", j), got_data[j], 64'hFFFF_FFFF_FFFF_FFFF - 64'(j));
            checkOutput($sformatf("q0_grant%0d", j), 64'(got_grant[j]), 64'd0);
        end
        checkOutput("q0_pulses", 64'(pulses), 64'd3);
        checkOutput("q0_bad_pulse", 64'(bad_pulse), 64'd0);
        checkOutput("q0_empty", 64'(qtail[0] - qhead[0]), 64'd0);

        // Four queues with two entries each; the first entry is held unacked.
        resetAll();
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 2; k++) qmem[i][k] = 64'(16 * i + k);
            qtail[i] = 2;
        end
        @(posedge clk);
        #1;
        checkOutput("stall_grant", 64'(gnt_a), 64'd0);
        checkOutput("stall_pulse", 64'(ack_a), 64'd1);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("stall%0d_valid", c), 64'(vout_a), 64'd1);
            checkOutput($sformatf("stall%0d_data", c), out_a, 64'd0);
            checkOutput($sformatf("stall%0d_pulse", c), 64'(ack_a), 64'd0);
        end
        checkOutput("stall_cnt0", 64'(qtail[0] - qhead[0]), 64'd1);
        for (int i = 1; i < 4; i++)
            checkOutput($sformatf("stall_cnt%0d", i), 64'(qtail[i] - qhead[i]), 64'd2);
        exp_t2 = '{64'd0, 64'd16, 64'd32, 64'd48, 64'd1, 64'd17, 64'd33, 64'd49};
        drain(1'b0, 8, 100);
        for (int j = 0; j < got_data.size(); j++) begin
            checkOutput($sformatf("rr_data%0d", j), got_data[j], exp_t2[j]);
            checkOutput($sformatf("rr_grant%0d", j), 64'(got_grant[j]), 64'(j % 4));
        end
        checkOutput("rr_pulses", 64'(pulses), 64'd7);
        checkOutput("rr_bad_pulse", 64'(bad_pulse), 64'd0);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("rr_empty%0d", i), 64'(qtail[i] - qhead[i]), 64'd0);

        // Three-queue instance drained end-to-end from full 16-entry fifos.
        resetAll();
        use_model = 1'b0;
        for (int q = 0; q < 3; q++) begin
            for (int k = 0; k < 16; k++) qmem[q+4][k] = {32'(q), 32'(k)};
            qtail[q+4] = 16;
            next_k[q]  = 0;
        end
        drain(1'b1, 48, 400);
        for (int j = 0; j < got_data.size(); j++) begin
            checkOutput($sformatf("e2e%0d_range", j), 64'(got_grant[j] < 2'd3), 64'd1);
            if (got_grant[j] < 2'd3) begin
                checkOutput($sformatf("e2e%0d_data", j), got_data[j],
                            {32'(got_grant[j]), 32'(next_k[got_grant[j]])});
                next_k[got_grant[j]]++;
            end
        end
        checkOutput("e2e_pulses", 64'(pulses), 64'd48);
        checkOutput("e2e_bad_pulse", 64'(bad_pulse), 64'd0);
        for (int q = 0; q < 3; q++)
            checkOutput($sformatf("e2e_empty%0d", q), 64'(qtail[q+4] - qhead[q+4]), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
